// File: rtl/int_cmt_collector_if.sv
// int_cmt_collector_if: commit-source handshake and writeback-slot bundle.
interface int_cmt_collector_if #(
  parameter int N_SRC     = 4,
  parameter int WB_PORTS  = 2,
  parameter int PAYLOAD_W = 64,
  parameter int SRC_W     = $clog2(N_SRC)
);
  logic                                flush_i;
  logic [N_SRC-1:0]                    cmt_valid_i;
  logic [N_SRC-1:0][PAYLOAD_W-1:0]     cmt_data_i;
  logic [N_SRC-1:0]                    cmt_ready_o;
  logic [WB_PORTS-1:0]                 wb_valid_o;
  logic [WB_PORTS-1:0][PAYLOAD_W-1:0]  wb_data_o;
  logic [WB_PORTS-1:0][SRC_W-1:0]      wb_src_o;
  logic                                wb_ready_i;
  modport slave (
    input  flush_i, cmt_valid_i, cmt_data_i, wb_ready_i,
    output cmt_ready_o, wb_valid_o, wb_data_o, wb_src_o
  );
  modport master (
    output flush_i, cmt_valid_i, cmt_data_i, wb_ready_i,
    input  cmt_ready_o, wb_valid_o, wb_data_o, wb_src_o
  );
endinterface

// File: rtl/int_cmt_collector.sv
// int_cmt_collector: round-robin collector of integer commit packets onto
// registered writeback slots, with flush and async reset discard.
module int_cmt_collector #(
  parameter int N_SRC     = 4,
  parameter int WB_PORTS  = 2,
  parameter int PAYLOAD_W = 64,
  parameter int SRC_W     = $clog2(N_SRC)
) (
  input logic                clk,
  input logic                a_rst_n,
  int_cmt_collector_if.slave bus
);
  logic [WB_PORTS-1:0]                wb_valid_q, wb_valid_d;
  logic [WB_PORTS-1:0][PAYLOAD_W-1:0] wb_data_q, wb_data_d;
  logic [WB_PORTS-1:0][SRC_W-1:0]     wb_src_q, wb_src_d;
  logic [SRC_W-1:0]                   rr_q, rr_d;
  logic [N_SRC-1:0]                   grant;
  logic                               advance, go;
  int                                 idx, n;
  assign advance = bus.wb_ready_i | ~(|wb_valid_q);
  assign go      = advance & ~bus.flush_i;
  // Gate with reset so no source sees ready while the slots are held clear.
  assign bus.cmt_ready_o = grant & {N_SRC{a_rst_n}};
  assign bus.wb_valid_o  = wb_valid_q;
  assign bus.wb_data_o   = wb_data_q;
  assign bus.wb_src_o    = wb_src_q;
  always_comb begin
    grant      = '0;
    wb_valid_d = '0;
    wb_data_d  = '0;
    wb_src_d   = '0;
    rr_d       = rr_q;
    n          = 0;
    idx        = 0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = (int'(rr_q) + k) % N_SRC;
      if (go && bus.cmt_valid_i[idx] && n < WB_PORTS) begin
        grant[idx]    = 1'b1;
        wb_valid_d[n] = 1'b1;
        wb_data_d[n]  = bus.cmt_data_i[idx];
        wb_src_d[n]   = SRC_W'(idx);
        rr_d          = SRC_W'((idx + 1) % N_SRC);
        n++;
      end
    end
  end
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      wb_valid_q <= '0;
      wb_data_q  <= '0;
      wb_src_q   <= '0;
      rr_q       <= '0;
    end else if (bus.flush_i) begin
      wb_valid_q <= '0;
      wb_data_q  <= '0;
      wb_src_q   <= '0;
    end else if (advance) begin
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_src_q   <= wb_src_d;
      rr_q       <= rr_d;
    end
  end
endmodule

// File: tb/tb_int_cmt_collector.sv
// tb_int_cmt_collector: directed vectors with hand-computed expectations.
module tb_int_cmt_collector;
  logic clk = 1'b0;
  logic a_rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int_cmt_collector_if #(.N_SRC(4), .WB_PORTS(2), .PAYLOAD_W(64)) bus ();
  int_cmt_collector #(.N_SRC(4), .WB_PORTS(2), .PAYLOAD_W(64)) dut (
    .clk(clk), .a_rst_n(a_rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] pay(int t, int i);
    return {8'(t), 8'(i), 48'hA5A5_5A5A_F00D};
  endfunction
  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic offer(int t, logic [3:0] v);
    bus.cmt_valid_i = v;
    for (int i = 0; i < 4; i++) bus.cmt_data_i[i] = pay(t, i);
    #1;
  endtask
  initial begin
    bus.flush_i = 1'b0;
    bus.wb_ready_i = 1'b1;
    bus.cmt_valid_i = '0;
    bus.cmt_data_i = '0;
    offer(0, 4'b1111);
    step();
    step();
    chk("rst_ready", bus.cmt_ready_o, 4'b0000);
    chk("rst_valid", bus.wb_valid_o, 2'b00);
    chk("rst_data", bus.wb_data_o, 128'h0);
    chk("rst_src", bus.wb_src_o, 4'h0);
    a_rst_n = 1'b1;
    offer(1, 4'b1111);
    chk("t1_ready01", bus.cmt_ready_o, 4'b0011);
    step();
    chk("t1_valid", bus.wb_valid_o, 2'b11);
    chk("t1_src01", bus.wb_src_o, 4'b0100);
    chk("t1_data0", bus.wb_data_o[0], pay(1, 0));
    chk("t1_data1", bus.wb_data_o[1], pay(1, 1));
    offer(1, 4'b1100);
    chk("t1_ready23", bus.cmt_ready_o, 4'b1100);
    step();
    chk("t1_src23", bus.wb_src_o, 4'b1110);
    chk("t1_data2", bus.wb_data_o[0], pay(1, 2));
    chk("t1_data3", bus.wb_data_o[1], pay(1, 3));
    offer(2, 4'b0011);
    step();
    offer(2, 4'b1000);
    chk("t2_ready", bus.cmt_ready_o, 4'b1000);
    step();
    chk("t2_valid", bus.wb_valid_o, 2'b01);
    chk("t2_src", bus.wb_src_o, 4'b0011);
    chk("t2_data0", bus.wb_data_o[0], pay(2, 3));
    chk("t2_data1", bus.wb_data_o[1], 64'h0);
    offer(3, 4'b0100);
    chk("t3_pre", bus.cmt_ready_o, 4'b0100);
    step();
    offer(3, 4'b1011);
    chk("t3_ready", bus.cmt_ready_o, 4'b1001);
    step();
    chk("t3_valid", bus.wb_valid_o, 2'b11);
    chk("t3_data0", bus.wb_data_o[0], pay(3, 3));
    chk("t3_data1", bus.wb_data_o[1], pay(3, 0));
    offer(4, 4'b1111);
    chk("t3_rr1", bus.cmt_ready_o, 4'b0110);
    step();
    chk("t3_src", bus.wb_src_o, 4'b1001);
    bus.wb_ready_i = 1'b0;
    offer(5, 4'b1111);
    for (int c = 0; c < 3; c++) begin
      chk("stall_ready", bus.cmt_ready_o, 4'b0000);
      step();
      chk("stall_valid", bus.wb_valid_o, 2'b11);
      chk("stall_src", bus.wb_src_o, 4'b1001);
      chk("stall_data", bus.wb_data_o, {pay(4, 2), pay(4, 1)});
    end
    bus.wb_ready_i = 1'b1;
    #1;
    chk("release_ready", bus.cmt_ready_o, 4'b1001);
    step();
    chk("release_src", bus.wb_src_o, 4'b0011);
    chk("release_data", bus.wb_data_o, {pay(5, 0), pay(5, 3)});
    bus.wb_ready_i = 1'b0;
    bus.flush_i = 1'b1;
    offer(6, 4'b1111);
    chk("flush_ready", bus.cmt_ready_o, 4'b0000);
    step();
    chk("flush_valid", bus.wb_valid_o, 2'b00);
    bus.flush_i = 1'b0;
    bus.wb_ready_i = 1'b1;
    #1;
    chk("flush_rr", bus.cmt_ready_o, 4'b0110);
    step();
    chk("flush_src", bus.wb_src_o, 4'b1001);
    chk("flush_data", bus.wb_data_o, {pay(6, 2), pay(6, 1)});
    a_rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.wb_valid_o, 2'b00);
    chk("arst_data", bus.wb_data_o, 128'h0);
    chk("arst_ready", bus.cmt_ready_o, 4'b0000);
    step();
    a_rst_n = 1'b1;
    offer(7, 4'b1111);
    chk("arst_rr0", bus.cmt_ready_o, 4'b0011);
    step();
    chk("arst_src", bus.wb_src_o, 4'b0100);
    chk("arst_data01", bus.wb_data_o, {pay(7, 1), pay(7, 0)});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
